fm_frame_collector: RTL

- Producer-side partner of the average-pool stage.
- Takes the preceding layer's serial pixel stream, one pixel pair per beat, on the full-rate clock.
- Assembles the pairs into two parallel DEPTH-entry feature-map frames (fm1, fm2) and holds each frame stable with a valid/ack handshake until the pool side consumes it.
- Replaces clock-ratio synchronisation with an explicit handshake, and double-buffers so the next frame fills while the current one is held.

---
 rtl/fm_frame_collector.sv | 111 +++++++++++
 1 files changed

// File: rtl/fm_frame_collector.sv
// Collects a serial stream of pixel pairs into two DEPTH-entry frames and
// presents each finished frame on a held, valid/ack-handshaked output bank.
module fm_frame_collector #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 64,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data_1,
  input  logic [DATA_W-1:0] in_data_2,
  input  logic              in_last,
  output logic [DATA_W-1:0] fm1 [0:DEPTH-1],
  output logic [DATA_W-1:0] fm2 [0:DEPTH-1],
  output logic              fm_valid,
  input  logic              fm_ack,
  output logic [7:0]        frame_cnt,
  output logic              sync_err
);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  state_t            state_q;
  state_t            state_d;
  logic [IDX_W-1:0]  wr_idx;
  logic              accept;
  logic              load;
  logic              at_last;
  logic [DATA_W-1:0] wbuf1 [0:DEPTH-1];
  logic [DATA_W-1:0] wbuf2 [0:DEPTH-1];

  assign at_last = (wr_idx == LAST_IDX);

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    accept   = 1'b0;
    load     = 1'b0;
    case (state_q)
      FILL: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (accept && at_last) state_d = FULL;
      end
      FULL: begin
        // The output bank is free when empty or being consumed this edge.
        load = !fm_valid || fm_ack;
        if (load) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FILL;
      wr_idx    <= '0;
      fm_valid  <= 1'b0;
      frame_cnt <= 8'd0;
      sync_err  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        wr_idx <= at_last ? '0 : wr_idx + IDX_W'(1);
        // in_last is only a cross-check; it never re-aligns the write index.
        if (in_last != at_last) sync_err <= 1'b1;
      end
      if (load) begin
        fm_valid  <= 1'b1;
        frame_cnt <= frame_cnt + 8'd1;
      end else if (fm_ack) begin
        fm_valid <= 1'b0;
      end
    end
  end

  // NOTE: the write buffer is deliberately not reset; every entry is
  // rewritten before it can be copied out, so clearing it only costs logic.
  always_ff @(posedge clk) begin
    if (accept && !rst) begin
      wbuf1[wr_idx] <= in_data_1;
      wbuf2[wr_idx] <= in_data_2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        fm1[i] <= '0;
        fm2[i] <= '0;
      end
    end else if (load) begin
      for (int i = 0; i < DEPTH; i++) begin
        fm1[i] <= wbuf1[i];
        fm2[i] <= wbuf2[i];
      end
    end
  end

endmodule
